// File: rtl/rr_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_n_if
// Brief    : Request/grant bundle between requesters and the round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_arbiter_n_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_n
// Brief    : N-way registered round-robin arbiter with bounded grant bursts.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_n #(
    parameter int N         = 4,
    parameter int MAX_BURST = 2,
    parameter int IDW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_n_if.slave bus
);
    localparam int             c_SW      = $clog2(N);
    localparam int             c_BW      = $clog2(MAX_BURST + 1);
    localparam logic [IDW-1:0] c_PTR_RST = IDW'(N - 1);

    logic [N-1:0]    r_gnt;
    logic [IDW-1:0]  r_gnt_id;
    logic            r_gnt_valid;
    logic [IDW-1:0]  r_ptr;
    logic [c_BW-1:0] r_bcnt;

    logic            w_any;
    logic            w_hold;
    logic            w_found;
    logic [c_SW-1:0] w_cur;
    logic [c_SW-1:0] w_sel;
    logic [N-1:0]    w_gnt_nxt;
    logic [IDW-1:0]  w_id_nxt;
    logic            w_valid_nxt;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [c_BW-1:0] w_bcnt_nxt;

    assign w_any  = |bus.req;
    assign w_cur  = c_SW'(r_gnt_id);
    assign w_hold = r_gnt_valid && bus.req[w_cur] && (r_bcnt < c_BW'(MAX_BURST));

    // Search ptr+1 .. ptr+N (mod N), so the last grantee is considered last.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(r_ptr) + k) % N;
            if (!w_found && bus.req[c_SW'(idx)]) begin
                w_found = 1'b1;
                w_sel   = c_SW'(idx);
            end
        end
    end

    always_comb begin
        w_gnt_nxt   = r_gnt;
        w_id_nxt    = r_gnt_id;
        w_valid_nxt = r_gnt_valid;
        w_ptr_nxt   = r_ptr;
        w_bcnt_nxt  = r_bcnt;
        if (!w_any) begin
            w_gnt_nxt   = '0;
            w_id_nxt    = '0;
            w_valid_nxt = 1'b0;
            w_bcnt_nxt  = '0;
        end else if (w_hold) begin
            w_bcnt_nxt  = r_bcnt + c_BW'(1);
        end else begin
            w_gnt_nxt   = N'(1) << w_sel;
            w_id_nxt    = IDW'(w_sel);
            w_valid_nxt = 1'b1;
            w_ptr_nxt   = IDW'(w_sel);
            w_bcnt_nxt  = c_BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= c_PTR_RST;
            r_bcnt      <= '0;
        end else begin
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_id_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_ptr       <= w_ptr_nxt;
            r_bcnt      <= w_bcnt_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = r_gnt_valid;
endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_n
// Brief    : Directed bench for rr_arbiter_n (N=4/MAX_BURST=2 and N=8/MAX_BURST=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_n;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    rr_arbiter_n_if #(.N(4), .IDW(2)) bus4 ();
    rr_arbiter_n_if #(.N(8), .IDW(3)) bus8 ();

    rr_arbiter_n #(.N(4), .MAX_BURST(2), .IDW(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    rr_arbiter_n #(.N(8), .MAX_BURST(1), .IDW(3)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Structural invariants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        int ones4, ones8, eid4, eid8;
        ones4 = 0; ones8 = 0; eid4 = 0; eid8 = 0;
        for (int i = 0; i < 4; i++) if (bus4.gnt[i]) begin ones4++; eid4 = i; end
        for (int i = 0; i < 8; i++) if (bus8.gnt[i]) begin ones8++; eid8 = i; end
        vectors++;
        if (ones4 > 1 || bus4.gnt_valid !== (ones4 == 1) || int'(bus4.gnt_id) != eid4) begin
            errors++;
            $display("FAIL mon4 gnt=%b id=%0d valid=%b required one-hot id=%0d valid=%0d",
                     bus4.gnt, bus4.gnt_id, bus4.gnt_valid, eid4, ones4 == 1);
        end
        vectors++;
        if (ones8 > 1 || bus8.gnt_valid !== (ones8 == 1) || int'(bus8.gnt_id) != eid8) begin
            errors++;
            $display("FAIL mon8 gnt=%b id=%0d valid=%b required one-hot id=%0d valid=%0d",
                     bus8.gnt, bus8.gnt_id, bus8.gnt_valid, eid8, ones8 == 1);
        end
        if (rst) begin
            vectors++;
            if (bus4.gnt !== 4'b0 || bus8.gnt !== 8'b0) begin
                errors++;
                $display("FAIL mon_rst gnt4=%b gnt8=%b required all zero", bus4.gnt, bus8.gnt);
            end
        end
    end

    task automatic test_reset();
        bus4.req = 4'b1111;
        bus8.req = 8'h00;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (bus4.gnt !== 4'b0 || bus4.gnt_id !== 2'd0 || bus4.gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d] gnt=%b id=%0d valid=%b required 0000/0/0",
                         i, bus4.gnt, bus4.gnt_id, bus4.gnt_valid);
            end
            vectors++;
            if (dut4.r_ptr !== 2'd3 || dut4.r_bcnt !== 2'd0) begin
                errors++;
                $display("FAIL reset_state ptr=%0d bcnt=%0d required 3/0", dut4.r_ptr, dut4.r_bcnt);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_full_load();
        logic [3:0] exp_g [0:8];
        exp_g = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                  4'b0100, 4'b1000, 4'b1000, 4'b0001};
        bus4.req = 4'b1111;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step();
            vectors++;
            if (bus4.gnt !== exp_g[i] || int'(bus4.gnt_id) != ((i / 2) % 4)) begin
                errors++;
                $display("FAIL full_load[%0d] gnt=%b id=%0d required %b id=%0d",
                         i, bus4.gnt, bus4.gnt_id, exp_g[i], (i / 2) % 4);
            end
        end
    endtask

    task automatic test_sole();
        bus4.req = 4'b0000;
        do_reset();
        bus4.req = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (bus4.gnt !== 4'b0100 || bus4.gnt_id !== 2'd2 ||
                int'(dut4.r_bcnt) != (i % 2) + 1) begin
                errors++;
                $display("FAIL sole[%0d] gnt=%b id=%0d bcnt=%0d required 0100 id=2 bcnt=%0d",
                         i, bus4.gnt, bus4.gnt_id, dut4.r_bcnt, (i % 2) + 1);
            end
        end
    endtask

    task automatic test_withdraw();
        logic [3:0] req_v [0:3];
        logic [3:0] exp_g [0:3];
        req_v = '{4'b0011, 4'b0010, 4'b0000, 4'b0011};
        exp_g = '{4'b0001, 4'b0010, 4'b0000, 4'b0001};
        bus4.req = 4'b0000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus4.req = req_v[i];
            step();
            vectors++;
            if (bus4.gnt !== exp_g[i] || bus4.gnt_valid !== (exp_g[i] != 4'b0)) begin
                errors++;
                $display("FAIL withdraw[%0d] gnt=%b valid=%b required %b",
                         i, bus4.gnt, bus4.gnt_valid, exp_g[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] req_v [0:6];
        logic [3:0] exp_g [0:6];
        req_v = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
        exp_g = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0001};
        bus4.req = 4'b0000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus4.req = req_v[i];
            step();
            vectors++;
            if (bus4.gnt !== exp_g[i]) begin
                errors++;
                $display("FAIL wrap[%0d] gnt=%b required %b", i, bus4.gnt, exp_g[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        bus4.req = 4'b0000;
        do_reset();
        bus4.req = 4'b0100;
        step();
        vectors++;
        if (bus4.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL async_pre gnt=%b required 0100", bus4.gnt);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus4.gnt !== 4'b0 || bus4.gnt_id !== 2'd0 || bus4.gnt_valid !== 1'b0 ||
            dut4.r_bcnt !== 2'd0) begin
            errors++;
            $display("FAIL async_now gnt=%b id=%0d valid=%b bcnt=%0d required 0000/0/0/0",
                     bus4.gnt, bus4.gnt_id, bus4.gnt_valid, dut4.r_bcnt);
        end
        bus4.req = 4'b1111;
        step();
        vectors++;
        if (bus4.gnt !== 4'b0) begin
            errors++;
            $display("FAIL async_held gnt=%b required 0000", bus4.gnt);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (bus4.gnt !== 4'b0001 || bus4.gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL async_first gnt=%b id=%0d required 0001 id=0", bus4.gnt, bus4.gnt_id);
        end
    endtask

    task automatic test_mb1();
        bus4.req = 4'b0000;
        bus8.req = 8'hFF;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] eg;
            eg = 8'h01 << (i % 8);
            step();
            vectors++;
            if (bus8.gnt !== eg || int'(bus8.gnt_id) != (i % 8)) begin
                errors++;
                $display("FAIL mb1[%0d] gnt=%b id=%0d required %b id=%0d",
                         i, bus8.gnt, bus8.gnt_id, eg, i % 8);
            end
        end
        bus8.req = 8'h00;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        test_reset();
        test_full_load();
        test_sole();
        test_withdraw();
        test_wrap();
        test_async_reset();
        test_mb1();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/rr_arbiter_n.md
RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 Parameter N, default 4: number of requesters, legal range 2..16.
REQ-002 Parameter MAX_BURST, default 2: maximum consecutive cycles one requester may hold the grant while others wait, legal range 1..16.
REQ-003 Parameter IDW, default $clog2(N): width of gnt_id, legal minimum 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  N  request vector; bit i set means requester i wants the resource.
REQ-007 gnt  output  N  registered one-hot grant, or all-zero when idle.
REQ-008 gnt_id  output  IDW  binary index of the granted requester; 0 when gnt_valid=0.
REQ-009 gnt_valid  output  1  high when any gnt bit is set.

Function
REQ-010 gnt, gnt_id and gnt_valid shall be driven directly from flops; no combinational path from req to any output.
REQ-011 Grant latency shall be one cycle: the decision is made from req sampled at edge k and becomes visible after edge k.
REQ-012 At most one gnt bit shall be set in any cycle.
REQ-013 Internal state: last-grantee pointer ptr (IDW bits), burst counter bcnt (0..MAX_BURST), registered grant.
REQ-014 Hold rule: if a requester g is granted, req[g]=1 and bcnt<MAX_BURST, grant stays on g and bcnt increments.
REQ-015 Rotate rule: otherwise, grant goes to the first set req bit searching from ptr+1 upward, wrapping modulo N, with ptr itself checked last.
REQ-016 On a new grant (including a re-grant of the same requester after burst expiry) bcnt shall load 1 and ptr shall load the granted index.
REQ-017 A sole requester whose burst has expired shall be re-granted with no idle cycle.
REQ-018 If req is all-zero, gnt shall go to 0, gnt_valid to 0 and bcnt to 0, and ptr shall keep its value.
REQ-019 Withdrawal: if the current grantee drops req, the next cycle shall follow the rotate rule, regardless of bcnt.
REQ-020 Requests arriving while another holds the grant shall wait at most MAX_BURST cycles before the grant moves.
REQ-021 Any single continuously asserted req bit shall be granted within (N-1)*MAX_BURST+1 cycles.
REQ-022 Wrap-around: with ptr=N-1 the search order shall be 0,1,...,N-1.
REQ-023 With MAX_BURST=1, behaviour shall reduce to a plain one-cycle round robin.
REQ-024 gnt_id shall always equal the encoded index of the set gnt bit in the same cycle.

Reset
REQ-025 When rst is asserted, gnt=0, gnt_id=0, gnt_valid=0 and bcnt=0 shall take effect immediately, without waiting for clk.
REQ-026 Reset shall set ptr=N-1, so req[0] has highest priority on the first decision.
REQ-027 Reset asserted mid-burst shall discard the burst; the first post-reset decision shall follow REQ-026.
REQ-028 Outputs shall remain at reset values while rst is high, whatever req does.

Verification (N=4, MAX_BURST=2 unless stated)
REQ-029 Full load: req=1111 held from reset release -> gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001, and gnt_id follows 0,0,1,1,2,2,3,3,0.
REQ-030 Sole requester: req=0100 held for 6 cycles -> gnt=0100 every cycle with no gap, and bcnt cycles 1,2,1,2.
REQ-031 Withdrawal and idle:
- req=0011 -> gnt 0001.
- Drop req[0] after 1 cycle -> next gnt 0010.
- req=0000 -> gnt 0000, gnt_valid 0.
- Then req=0011 -> gnt 0001 (ptr=1, search 2,3,0).
REQ-032 Wrap: ptr=3 reached via req=1000, then req=1001 -> gnt order 0001 then 1000.
REQ-033 Async reset: assert rst mid-cycle during burst on requester 2 -> gnt=0000 before the next clk edge. After release with req=1111, first gnt=0001.
REQ-034 MAX_BURST=1, N=8, req=all-ones -> one-hot grant rotates 0..7 one cycle each. Check one-hot and gnt_id consistency every cycle in all tests.
